// File: rtl/matcher.sv
// Scans a vocabulary of null-terminated byte tokens for the current query word and reports the matching token index.
// Result arrives as a one-cycle match_valid pulse; a change of word restarts the scan and no pulse is issued for the abandoned one.

module matcher_incr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] curr_addr,
    output logic                  overflow
);
    assign overflow = inc && (curr_addr == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            curr_addr <= '0;
        else if (clear)
            curr_addr <= '0;
        else if (inc)
            curr_addr <= curr_addr + 1'b1;
    end
endmodule

module matcher_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LOAD_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             load,
    input  logic [LOAD_BYTES*DATA_WIDTH-1:0] load_dat,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            dout
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Bulk load writes the whole query plus its terminating null in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            dout <= '0;
        end else begin
            dout <= mem[raddr];
            if (load) begin
                for (int i = 0; i < LOAD_BYTES; i++)
                    mem[i] <= load_dat[(LOAD_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH];
                mem[ADDR_WIDTH'(LOAD_BYTES)] <= '0;
            end else if (we) begin
                mem[waddr] <= wdata;
            end
        end
    end
endmodule

module matcher #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    input  logic                              vocab_we,
    input  logic [ADDR_WIDTH-1:0]             vocab_waddr,
    input  logic [DATA_WIDTH-1:0]             vocab_wdata,
    output logic                              busy,
    output logic                              match_valid,
    output logic                              match_found,
    output logic [ADDR_WIDTH-1:0]             match_index
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_CMP, S_SKIP, S_SKIP_RD, S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0]             token_idx_q, token_idx_d;
    logic                              found_q, found_d;
    logic [ADDR_WIDTH-1:0]             index_q, index_d;

    logic                  vocab_clr, vocab_inc, input_clr, input_inc, load_en;
    logic [ADDR_WIDTH-1:0] vocab_addr, input_addr;
    logic [DATA_WIDTH-1:0] vocab_dout, input_dout;
    logic                  vocab_overflow, input_overflow;
    logic                  nullptr_vocab, nullptr_input;
    logic                  word_chg, scanning;

    matcher_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LOAD_BYTES(1)) vocab_ram (
        .clk(clk), .rst(rst_n), .we(vocab_we), .waddr(vocab_waddr), .wdata(vocab_wdata),
        .load(1'b0), .load_dat('0), .raddr(vocab_addr), .dout(vocab_dout)
    );

    matcher_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LOAD_BYTES(WORD_LENGTH)) input_ram (
        .clk(clk), .rst(rst_n), .we(1'b0), .waddr('0), .wdata('0),
        .load(load_en), .load_dat(word_q), .raddr(input_addr), .dout(input_dout)
    );

    matcher_incr #(.ADDR_WIDTH(ADDR_WIDTH)) vocab_incr (
        .clk(clk), .rst(rst_n), .clear(vocab_clr), .inc(vocab_inc),
        .curr_addr(vocab_addr), .overflow(vocab_overflow)
    );

    matcher_incr #(.ADDR_WIDTH(ADDR_WIDTH)) input_incr (
        .clk(clk), .rst(rst_n), .clear(input_clr), .inc(input_inc),
        .curr_addr(input_addr), .overflow(input_overflow)
    );

    assign nullptr_vocab = (vocab_dout == '0);
    assign nullptr_input = (input_dout == '0);
    assign word_chg      = (word != word_q);
    assign scanning      = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        token_idx_d = token_idx_q;
        found_d     = found_q;
        index_d     = index_q;
        vocab_clr   = 1'b0;
        vocab_inc   = 1'b0;
        input_clr   = 1'b0;
        input_inc   = 1'b0;
        load_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (word_chg) begin
                    word_d = word;
                    if (word != '0)
                        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_en     = 1'b1;
                vocab_clr   = 1'b1;
                input_clr   = 1'b1;
                token_idx_d = '0;
                found_d     = 1'b0;
                index_d     = '0;
                state_d     = S_FETCH;
            end
            S_FETCH: state_d = S_CMP;
            S_CMP: begin
                if (nullptr_vocab && (input_addr == '0)) begin
                    state_d = S_DONE;
                end else if (nullptr_vocab && nullptr_input) begin
                    found_d = 1'b1;
                    index_d = token_idx_q;
                    state_d = S_DONE;
                end else if (vocab_dout == input_dout) begin
                    vocab_inc = 1'b1;
                    input_inc = 1'b1;
                    state_d   = (vocab_overflow || input_overflow) ? S_DONE : S_FETCH;
                end else begin
                    state_d = S_SKIP;
                end
            end
            S_SKIP: begin
                // Each skipped byte costs a step cycle plus a read cycle.
                vocab_inc = 1'b1;
                if (vocab_overflow) begin
                    state_d = S_DONE;
                end else if (nullptr_vocab) begin
                    input_clr   = 1'b1;
                    token_idx_d = token_idx_q + 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_SKIP_RD;
                end
            end
            S_SKIP_RD: state_d = S_SKIP;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // A new query abandons the scan silently; the held result stays untouched.
        if (scanning && word_chg) begin
            word_d  = word;
            found_d = found_q;
            index_d = index_q;
            state_d = (word != '0) ? S_LOAD : S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            token_idx_q <= '0;
            found_q     <= 1'b0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            token_idx_q <= token_idx_d;
            found_q     <= found_d;
            index_q     <= index_d;
        end
    end

    assign busy        = scanning;
    assign match_valid = (state_q == S_DONE);
    assign match_found = found_q;
    assign match_index = index_q;
endmodule

// File: tb/tb_matcher.sv
// Directed bench for matcher: vocabulary "Hi\0Hel\0\0", an all-'A' vocabulary for wrap, mid-scan word change and reset.

module tb_matcher;
    localparam int AW = 4;
    localparam int WL = 3;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [WL*DW-1:0] word;
    logic            vocab_we;
    logic [AW-1:0]   vocab_waddr;
    logic [DW-1:0]   vocab_wdata;
    logic            busy, match_valid, match_found;
    logic [AW-1:0]   match_index;

    matcher #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .word(word), .vocab_we(vocab_we),
        .vocab_waddr(vocab_waddr), .vocab_wdata(vocab_wdata), .busy(busy),
        .match_valid(match_valid), .match_found(match_found), .match_index(match_index)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int ovf_cnt = 0;
    logic          last_found = 1'b0;
    logic [AW-1:0] last_idx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (match_valid) begin
            pulses++;
            last_found = match_found;
            last_idx   = match_index;
        end
        if (dut.vocab_overflow)
            ovf_cnt++;
    end

    task automatic vwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        vocab_we    = 1'b1;
        vocab_waddr = a;
        vocab_wdata = d;
        @(posedge clk);
        #3;
        vocab_we = 1'b0;
    endtask

    task automatic scan(input string tag, input logic [WL*DW-1:0] w,
                        input logic exp_found, input logic [AW-1:0] exp_idx);
        int  p0;
        logic ok;
        logic saw_busy;
        p0 = pulses;
        ok = 1'b0;
        saw_busy = 1'b0;
        word = w;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #3;
            if (busy) saw_busy = 1'b1;
            if (pulses != p0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, ok, 1'b1);
        check({tag, "_busy"}, saw_busy, 1'b1);
        check({tag, "_found"}, last_found, exp_found);
        check({tag, "_index"}, last_idx, exp_idx);
    endtask

    initial begin
        int p0;
        int nz;
        logic [7:0] voc [8];
        voc = '{8'h48, 8'h69, 8'h00, 8'h48, 8'h65, 8'h6C, 8'h00, 8'h00};

        rst_n = 1'b1;
        word = '0;
        vocab_we = 1'b0;
        vocab_waddr = '0;
        vocab_wdata = '0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", match_valid, 1'b0);
        check("rst_found", match_found, 1'b0);
        check("rst_index", match_index, 4'd0);
        rst_n = 1'b0;

        for (int i = 0; i < 8; i++) vwr(AW'(i), voc[i]);

        scan("hel", 24'h48656C, 1'b1, 4'd1);
        check("load_mem0", dut.input_ram.mem[0], 8'h48);
        check("load_mem1", dut.input_ram.mem[1], 8'h65);
        check("load_mem2", dut.input_ram.mem[2], 8'h6C);
        check("load_mem3", dut.input_ram.mem[3], 8'h00);

        scan("hex", 24'h486578, 1'b0, 4'd0);
        scan("hi", 24'h486900, 1'b1, 4'd0);

        // Start "Hex", switch to "Hel" while the first scan is in FETCH.
        p0 = pulses;
        word = 24'h486578;
        repeat (2) begin
            @(posedge clk);
            #3;
        end
        scan("abort", 24'h48656C, 1'b1, 4'd1);
        repeat (10) @(posedge clk);
        #3;
        check("abort_pulses", pulses - p0, 1);

        for (int i = 0; i < 16; i++) vwr(AW'(i), 8'h41);
        ovf_cnt = 0;
        scan("wrap", 24'h414142, 1'b0, 4'd0);
        check("wrap_ovf_seen", (ovf_cnt > 0), 1'b1);

        word = 24'h414141;
        repeat (3) begin
            @(posedge clk);
            #3;
        end
        check("pre_rst_busy", busy, 1'b1);
        p0 = pulses;
        rst_n = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_vaddr", dut.vocab_incr.curr_addr, 4'd0);
        check("mid_rst_iaddr", dut.input_incr.curr_addr, 4'd0);
        nz = 0;
        for (int i = 0; i < 16; i++)
            if (dut.vocab_ram.mem[i] != 8'h00 || dut.input_ram.mem[i] != 8'h00) nz++;
        check("mid_rst_mem_zero", nz, 0);
        word = '0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("rst_no_pulse", pulses - p0, 0);
        check("zero_word_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matcher.md
Name: matcher

Overview:
- Matches a fixed-length input word of bytes against a vocabulary of null-terminated byte tokens held in an internal vocabulary RAM.
- Sits between a token/character front end, which supplies `word`, and downstream logic that consumes the matching token index.
- Internally holds two RAMs (`vocab_ram`, `input_ram`) and two address incrementers (`vocab_incr`, `input_incr`), sequenced by a compare FSM.

Parameters:
- ADDR_WIDTH, 4, address width of both RAMs; depth = 2^ADDR_WIDTH.
- WORD_LENGTH, 3, number of bytes in `word`; must be < 2^ADDR_WIDTH.
- DATA_WIDTH, 8, byte width of `word` and of each RAM entry.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-high (asserted when 1, despite the name).
- word  in  WORD_LENGTH*DATA_WIDTH  query; byte 0 = MSB slice.
- vocab_we  in  1  vocabulary write enable.
- vocab_waddr  in  ADDR_WIDTH  vocabulary write address.
- vocab_wdata  in  DATA_WIDTH  vocabulary write data.
- busy  out  1  scan in progress.
- match_valid  out  1  one-cycle pulse at end of scan.
- match_found  out  1  result, valid while match_valid is high.
- match_index  out  ADDR_WIDTH  0-based token number of the match; 0 when there is no match.

Behaviour:
- Reset:
  - All registers, both RAM arrays, `curr_addr`, `dout` and outputs go to 0.
  - FSM goes to IDLE.
  - `word_q` (the stored copy of `word`) is cleared.
- RAMs:
  - Depth 2^ADDR_WIDTH × DATA_WIDTH; storage array named `mem`.
  - Synchronous read: `dout` is valid 1 cycle after the address is applied.
- Vocab writes:
  - A `vocab_ram` write occurs whenever `vocab_we` = 1.
  - Writes made during a scan take effect, but the results of that scan are undefined.
- Incrementer (`curr_addr` register):
  - `clear` takes priority over `inc`.
  - `inc` wraps from 2^ADDR_WIDTH−1 to 0.
  - `overflow` is asserted combinationally when `inc` = 1 and `curr_addr` is all-ones.
- Status signals:
  - `nullptr_vocab` = (`vocab_ram.dout` == 0).
  - `nullptr_input` = (`input_ram.dout` == 0).
  - `vocab_overflow` and `input_overflow` are the incrementer overflow flags.
- IDLE:
  - When `word` != `word_q`, capture `word` into `word_q` and go to LOAD.
  - `word` = 0 is never scanned.
- LOAD (1 cycle):
  - `input_ram.mem[i]` ← byte i of `word_q` for i = 0..WORD_LENGTH−1; `mem[WORD_LENGTH]` ← 0.
  - Example: "Hel" = {8'h48,8'h65,8'h6C} gives mem[0]=48, mem[1]=65, mem[2]=6C, mem[3]=00.
  - Clear both incrementers and `token_idx`; set `busy`; go to FETCH.
- FETCH: present both addresses; go to COMPARE next cycle.
- COMPARE, first matching rule applies:
  1. `nullptr_vocab` and input address = 0 (empty token, end of vocabulary) → DONE, no match.
  2. `nullptr_vocab` and `nullptr_input` → DONE, match, `match_index` = `token_idx`.
  3. Bytes equal and non-null → inc both incrementers, FETCH.
  4. Otherwise (mismatch) → SKIP.
- SKIP:
  - Increment the vocab address each cycle, with a 2-cycle read per byte, until a null is read.
  - Then step past the null, clear the input incrementer, `token_idx`++, go to FETCH.
- A zero byte inside `word` terminates the query early: "He\0" matches token "He".
- `vocab_overflow` in any state → DONE, no match, so wrap never re-scans the vocabulary.
- `input_overflow` cannot occur, given the WORD_LENGTH constraint.
- DONE (1 cycle): `match_valid` = 1; `busy` = 0; `match_found`/`match_index` held until the next scan starts; return to IDLE.
- `word` changes mid-scan: abort at the next edge, capture the new `word`, go to LOAD; no `match_valid` is issued for the aborted scan.
- Reset mid-scan: immediate abort; no pulse.

Test Plan:
- Reset, then write vocab "Hi\0Hel\0\0" (48 69 00 48 65 6C 00 00) at addresses 0..7, then `word` = {48,65,6C} → after LOAD, input_ram.mem = 48 65 6C 00; `match_valid` pulse with `match_found`=1, `match_index`=1.
- Same vocab, `word` = {48,65,78} ("Hex") → `match_valid` pulse, `match_found`=0, `match_index`=0.
- Same vocab, `word` = {48,69,00} → `match_found`=1, `match_index`=0.
- Vocab filled with 16 × 0x41, `word` = {41,41,42} → `vocab_overflow` seen during SKIP; `match_found`=0; `vocab_incr.curr_addr` never re-scans.
- Change `word` from "Hex" to "Hel" two cycles into a scan → exactly one `match_valid`, with `match_index`=1.
- Assert `rst_n`=1 mid-scan → `busy`=0, all `curr_addr`=0, both `mem` arrays all 0, no pulse.
